// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI mode-0 slave.
package spi_slave_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DATA_W_DEF    = 8;
    localparam int RX_FIFO_DEPTH = 4;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with rise/fall detection for one asynchronous SPI pin.
module spi_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic [STAGES:0]   primed;

    // Edges stay masked until the chain holds only real pin samples, so a pin
    // that sits at the non-reset level after rst does not fake an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain  <= {STAGES{INIT}};
            prev   <= INIT;
            primed <= '0;
        end else begin
            chain  <= (chain << 1) | STAGES'(d);
            prev   <= q;
            primed <= {primed[STAGES-1:0], 1'b1};
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = primed[STAGES] &  q & ~prev;
    assign fall = primed[STAGES] & ~q &  prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave with valid/ready byte channels.
// Define SPI_SLAVE_RX_FIFO_EN to buffer received frames in a small RX FIFO.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk_i,
    input  logic              spi_cs_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              tx_underrun_o,
    output logic              rx_overrun_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state, state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift, rx_shift, hold_data, rx_word;
    logic              hold_valid, tx_load, frame_start, frame_done;
    logic              sclk_rise, sclk_fall, cs_rise, cs_fall, mosi;
    logic              unused_sclk_level, unused_cs_level, unused_mosi_rise, unused_mosi_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(spi_clk_i),
        .q(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(spi_cs_i),
        .q(unused_cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(spi_mosi_i),
        .q(mosi), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    assign rx_word    = {rx_shift[DATA_W-2:0], mosi};
    assign tx_ready_o = ~hold_valid;
    assign tx_load    = tx_valid_i & ~hold_valid;
    assign spi_miso_o = (state == SHIFT) ? tx_shift[DATA_W-1] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A frame boundary is either CS falling or the counter wrapping while CS stays low.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next  = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end else if (sclk_rise && bit_cnt == CNT_W'(DATA_W - 1)) begin
                    frame_done  = 1'b1;
                    frame_start = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The falling edge right after a wrap is skipped so the freshly loaded MSB survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data     <= '0;
            hold_valid    <= 1'b0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            tx_underrun_o <= 1'b0;
        end else begin
            if (tx_load) hold_data <= tx_data_i;
            hold_valid    <= tx_load | (hold_valid & ~frame_start);
            tx_underrun_o <= frame_start & ~hold_valid;

            if (frame_start)
                tx_shift <= hold_valid ? hold_data : '0;
            else if (state == SHIFT && sclk_fall && bit_cnt != '0)
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

            if (state == IDLE || cs_rise) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                rx_shift <= rx_word;
                bit_cnt  <= frame_done ? '0 : bit_cnt + 1'b1;
            end
        end
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);

    logic [DATA_W-1:0] fifo_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_count;
    logic              fifo_full, push, pop;

    assign fifo_full  = (fifo_count == (PTR_W+1)'(RX_FIFO_DEPTH));
    assign pop        = rx_valid_o & rx_ready_i;
    assign push       = frame_done & (~fifo_full | pop);
    assign rx_valid_o = (fifo_count != '0);
    assign rx_data_o  = fifo_mem[rd_ptr];

    // A pop in the same cycle frees the slot a full FIFO needs for the incoming frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            rx_overrun_o <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= rx_word;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count   <= fifo_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            rx_overrun_o <= frame_done & fifo_full & ~pop;
        end
    end
`else
    logic unused_rx_ready;
    assign unused_rx_ready = rx_ready_i;
    assign rx_overrun_o    = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
        end else begin
            rx_valid_o <= frame_done;
            if (frame_done) rx_data_o <= rx_word;
        end
    end
`endif

endmodule
